// File: rtl/alu_rs_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs_unit
// Purpose  : Tomasulo integer ALU with NUM_RS reservation stations, CDB snoop,
//            EXEC_LAT-deep pipelined execute and CDB_rts/CDB_xmit transmit.
//            Optional macro ALU_SHIFT_EN enables opcodes 010 (sll) / 011 (sra).
// Revision : 1.0  initial release
// ============================================================================
module alu_rs_unit #(
    parameter int WIDTH    = 32,
    parameter int NUM_RS   = 3,
    parameter int TAG_W    = 6,
    parameter int TAG_BASE = 1,
    parameter int EXEC_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue,
    input  logic [5:0]        opcode,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic              A_invalid,
    input  logic              B_invalid,
    input  logic              CDB_in_write,
    input  logic [TAG_W-1:0]  CDB_in_source,
    input  logic [WIDTH-1:0]  CDB_in_data,
    input  logic              CDB_xmit,
    output logic [WIDTH-1:0]  CDB_data,
    output logic [TAG_W-1:0]  CDB_source,
    output logic              CDB_write,
    output logic              CDB_rts,
    output logic              available,
    output logic [NUM_RS-1:0] RS_available,
    output logic [NUM_RS-1:0] issued,
    output logic [NUM_RS-1:0] RS_executing,
    output logic              error
);

    localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
`ifdef ALU_SHIFT_EN
    localparam int SH_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`endif

    localparam logic [2:0] S_FREE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_READY = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    function automatic logic [WIDTH-1:0] f_alu(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b100:  r = a | b;
            3'b101:  r = a & b;
            3'b110:  r = ~a;
            3'b111:  r = a ^ b;
`ifdef ALU_SHIFT_EN
            3'b010:  r = a << b[SH_W-1:0];
            3'b011:  r = WIDTH'($signed(a) >>> b[SH_W-1:0]);
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    // Station storage; while an operand is invalid its low TAG_W bits hold the producer tag
    logic [2:0]       r_state [NUM_RS];
    logic [2:0]       r_op    [NUM_RS];
    logic [WIDTH-1:0] r_a     [NUM_RS];
    logic [WIDTH-1:0] r_b     [NUM_RS];
    logic             r_a_inv [NUM_RS];
    logic             r_b_inv [NUM_RS];

    logic [2:0]       w_st_nxt  [NUM_RS];
    logic [2:0]       w_op_nxt  [NUM_RS];
    logic [WIDTH-1:0] w_a_nxt   [NUM_RS];
    logic [WIDTH-1:0] w_b_nxt   [NUM_RS];
    logic             w_ai_nxt  [NUM_RS];
    logic             w_bi_nxt  [NUM_RS];

    logic             r_pv   [EXEC_LAT];
    logic [IDX_W-1:0] r_pidx [EXEC_LAT];
    logic [WIDTH-1:0] r_pres [EXEC_LAT];

    logic [NUM_RS-1:0] r_issued;
    logic              r_error;

    logic              w_legal, w_avail, w_do_issue, w_found_free;
    logic [NUM_RS-1:0] w_alloc_oh, w_free;
    logic              w_start_any;
    logic [NUM_RS-1:0] w_start_oh;
    logic [IDX_W-1:0]  w_start_idx;
    logic [2:0]        w_sop;
    logic [WIDTH-1:0]  w_sa, w_sb;
    logic              w_a_byp, w_b_byp;
    logic              w_any_done, w_tx_found;
    logic [NUM_RS-1:0] w_tx_oh;
    logic              w_unused;

    assign w_unused = &{1'b0, opcode[5:3]};

    always_comb begin
        case (opcode[2:0])
`ifdef ALU_SHIFT_EN
            3'b010, 3'b011: w_legal = 1'b1;
`else
            3'b010, 3'b011: w_legal = 1'b0;
`endif
            default:        w_legal = 1'b1;
        endcase
    end

    // Priority selection: allocation, execute start and transmit all favour the lowest index
    always_comb begin
        w_free       = '0;
        w_alloc_oh   = '0;
        w_found_free = 1'b0;
        w_start_any  = 1'b0;
        w_start_oh   = '0;
        w_start_idx  = '0;
        w_sop        = '0;
        w_sa         = '0;
        w_sb         = '0;
        w_any_done   = 1'b0;
        w_tx_found   = 1'b0;
        w_tx_oh      = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            w_free[i] = (r_state[i] == S_FREE);
            if (!w_found_free && r_state[i] == S_FREE) begin
                w_found_free  = 1'b1;
                w_alloc_oh[i] = 1'b1;
            end
            if (!w_start_any && r_state[i] == S_READY) begin
                w_start_any   = 1'b1;
                w_start_oh[i] = 1'b1;
                w_start_idx   = IDX_W'(i);
                w_sop         = r_op[i];
                w_sa          = r_a[i];
                w_sb          = r_b[i];
            end
            if (r_state[i] == S_DONE) begin
                w_any_done = 1'b1;
                if (!w_tx_found) begin
                    w_tx_found = 1'b1;
                    w_tx_oh[i] = CDB_xmit;
                end
            end
        end
        w_avail    = w_found_free;
        w_do_issue = issue && w_avail && w_legal;
        if (!w_do_issue)
            w_alloc_oh = '0;
    end

    assign w_a_byp = A_invalid && CDB_in_write && (CDB_in_source == A[TAG_W-1:0]);
    assign w_b_byp = B_invalid && CDB_in_write && (CDB_in_source == B[TAG_W-1:0]);

    // Next-state / next-data for every station
    always_comb begin
        for (int i = 0; i < NUM_RS; i++) begin
            w_st_nxt[i] = r_state[i];
            w_op_nxt[i] = r_op[i];
            w_a_nxt[i]  = r_a[i];
            w_b_nxt[i]  = r_b[i];
            w_ai_nxt[i] = r_a_inv[i];
            w_bi_nxt[i] = r_b_inv[i];
            case (r_state[i])
                S_FREE: if (w_alloc_oh[i]) begin
                    w_op_nxt[i] = opcode[2:0];
                    w_a_nxt[i]  = w_a_byp ? CDB_in_data : A;
                    w_b_nxt[i]  = w_b_byp ? CDB_in_data : B;
                    w_ai_nxt[i] = A_invalid && !w_a_byp;
                    w_bi_nxt[i] = B_invalid && !w_b_byp;
                    w_st_nxt[i] = (w_ai_nxt[i] || w_bi_nxt[i]) ? S_WAIT : S_READY;
                end
                S_WAIT: begin
                    if (r_a_inv[i] && CDB_in_write && CDB_in_source == r_a[i][TAG_W-1:0]) begin
                        w_a_nxt[i]  = CDB_in_data;
                        w_ai_nxt[i] = 1'b0;
                    end
                    if (r_b_inv[i] && CDB_in_write && CDB_in_source == r_b[i][TAG_W-1:0]) begin
                        w_b_nxt[i]  = CDB_in_data;
                        w_bi_nxt[i] = 1'b0;
                    end
                    if (!w_ai_nxt[i] && !w_bi_nxt[i])
                        w_st_nxt[i] = S_READY;
                end
                S_READY: if (w_start_oh[i]) w_st_nxt[i] = S_EXEC;
                S_EXEC: if (r_pv[EXEC_LAT-1] && r_pidx[EXEC_LAT-1] == IDX_W'(i)) begin
                    w_st_nxt[i] = S_DONE;
                    w_a_nxt[i]  = r_pres[EXEC_LAT-1];
                end
                S_DONE: if (w_tx_oh[i]) w_st_nxt[i] = S_FREE;
                default: w_st_nxt[i] = S_FREE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_RS; i++) begin
                r_state[i] <= S_FREE;
                r_op[i]    <= '0;
                r_a[i]     <= '0;
                r_b[i]     <= '0;
                r_a_inv[i] <= 1'b0;
                r_b_inv[i] <= 1'b0;
            end
            for (int k = 0; k < EXEC_LAT; k++) begin
                r_pv[k]   <= 1'b0;
                r_pidx[k] <= '0;
                r_pres[k] <= '0;
            end
            r_issued <= '0;
            r_error  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_RS; i++) begin
                r_state[i] <= w_st_nxt[i];
                r_op[i]    <= w_op_nxt[i];
                r_a[i]     <= w_a_nxt[i];
                r_b[i]     <= w_b_nxt[i];
                r_a_inv[i] <= w_ai_nxt[i];
                r_b_inv[i] <= w_bi_nxt[i];
            end
            // The result is computed at start and carried down the pipe; DONE's result lives in r_a
            r_pv[0]   <= w_start_any;
            r_pidx[0] <= w_start_idx;
            r_pres[0] <= f_alu(w_sop, w_sa, w_sb);
            for (int k = 1; k < EXEC_LAT; k++) begin
                r_pv[k]   <= r_pv[k-1];
                r_pidx[k] <= r_pidx[k-1];
                r_pres[k] <= r_pres[k-1];
            end
            r_issued <= w_alloc_oh;
            r_error  <= issue && !(w_avail && w_legal);
        end
    end

    always_comb begin
        CDB_data     = '0;
        CDB_source   = '0;
        RS_executing = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            RS_executing[i] = (r_state[i] == S_EXEC);
            if (w_tx_oh[i]) begin
                CDB_data   = r_a[i];
                CDB_source = TAG_W'(TAG_BASE + i);
            end
        end
        CDB_rts      = w_any_done;
        CDB_write    = |w_tx_oh;
        available    = w_avail;
        RS_available = w_free;
        issued       = r_issued;
        error        = r_error;
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_rs_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rs_unit
// Purpose  : Directed self-checking bench for alu_rs_unit with a result scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_rs_unit;

    localparam int WIDTH = 32;
    localparam int NRS   = 3;
    localparam int TW    = 6;

    logic             clock = 1'b0;
    logic             reset;
    logic             issue;
    logic [5:0]       opcode;
    logic [WIDTH-1:0] A, B;
    logic             A_invalid, B_invalid;
    logic             CDB_in_write;
    logic [TW-1:0]    CDB_in_source;
    logic [WIDTH-1:0] CDB_in_data;
    logic             CDB_xmit;
    logic [WIDTH-1:0] CDB_data;
    logic [TW-1:0]    CDB_source;
    logic             CDB_write, CDB_rts, available, error;
    logic [NRS-1:0]   RS_available, issued, RS_executing;

    int checks   = 0;
    int failures = 0;
    int stray    = 0;
    logic flush_win = 1'b0;
    logic [WIDTH+TW-1:0] sb_q[$];

    alu_rs_unit #(.WIDTH(WIDTH), .NUM_RS(NRS), .TAG_W(TW), .TAG_BASE(1), .EXEC_LAT(2)) dut (
        .clock(clock), .reset(reset), .issue(issue), .opcode(opcode),
        .A(A), .B(B), .A_invalid(A_invalid), .B_invalid(B_invalid),
        .CDB_in_write(CDB_in_write), .CDB_in_source(CDB_in_source), .CDB_in_data(CDB_in_data),
        .CDB_xmit(CDB_xmit), .CDB_data(CDB_data), .CDB_source(CDB_source),
        .CDB_write(CDB_write), .CDB_rts(CDB_rts), .available(available),
        .RS_available(RS_available), .issued(issued), .RS_executing(RS_executing),
        .error(error)
    );

    always #5 clock = ~clock;

    always @(negedge clock)
        if (flush_win && CDB_write) stray++;

    function automatic logic [WIDTH-1:0] model(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b100:  return a | b;
            3'b101:  return a & b;
            3'b110:  return ~a;
            3'b111:  return a ^ b;
            3'b010:  return a << b[4:0];
            default: return $unsigned($signed(a) >>> b[4:0]);
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_issue(input logic [2:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic ai, input logic bi);
        issue = 1'b1; opcode = {3'b000, op}; A = a; B = b; A_invalid = ai; B_invalid = bi;
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] d, input logic [TW-1:0] s);
        sb_q.push_back({d, s});
    endtask

    // Compare the currently driven CDB word against the scoreboard head
    task automatic cmp_tx(input string tag);
        logic [WIDTH+TW-1:0] e;
        check({tag, "_write"}, 64'(CDB_write), 64'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_data"}, 64'(CDB_data), 64'(e[WIDTH+TW-1:TW]));
            check({tag, "_src"},  64'(CDB_source), 64'(e[TW-1:0]));
        end
    endtask

    task automatic do_xmit(input string tag);
        CDB_xmit = 1'b1;
        #1;
        cmp_tx(tag);
        tick();
        CDB_xmit = 1'b0;
    endtask

    task automatic wait_rts(input string tag);
        int n;
        n = 0;
        while (!CDB_rts && n < 20) begin tick(); n++; end
        check({tag, "_rts_timeout"}, 64'(CDB_rts), 64'd1);
    endtask

    initial begin
        reset = 1'b1; issue = 1'b0; opcode = '0; A = '0; B = '0;
        A_invalid = 1'b0; B_invalid = 1'b0; CDB_in_write = 1'b0;
        CDB_in_source = '0; CDB_in_data = '0; CDB_xmit = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_avail", 64'(available), 64'd1);
        check("rst_rs_avail", 64'(RS_available), 64'b111);
        check("rst_issued", 64'(issued), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_rts", 64'(CDB_rts), 64'd0);
        check("rst_write", 64'(CDB_write), 64'd0);

        // add 5+5: start one cycle after issue, DONE EXEC_LAT cycles after start
        drive_issue(3'b000, 32'd5, 32'd5, 1'b0, 1'b0);
        push_exp(model(3'b000, 32'd5, 32'd5), 6'd1);
        tick(); issue = 1'b0;
        check("add_issued", 64'(issued), 64'b001);
        tick();
        check("add_exec", 64'(RS_executing), 64'b001);
        check("add_issued_clr", 64'(issued), 64'd0);
        tick();
        check("add_rts_early", 64'(CDB_rts), 64'd0);
        tick();
        check("add_rts", 64'(CDB_rts), 64'd1);
        check("add_nowrite", 64'(CDB_write), 64'd0);
        do_xmit("add");
        check("add_freed", 64'(RS_available), 64'b111);

        // sub with A waiting on tag 9
        drive_issue(3'b001, 32'd9, 32'd13, 1'b1, 1'b0);
        tick(); issue = 1'b0;
        tick(); tick(); tick();
        check("sub_wait_rts", 64'(CDB_rts), 64'd0);
        check("sub_wait_exec", 64'(RS_executing), 64'd0);
        check("sub_wait_busy", 64'(RS_available), 64'b110);
        CDB_in_write = 1'b1; CDB_in_source = 6'd9; CDB_in_data = 32'd3;
        push_exp(32'hFFFF_FFF6, 6'd1);
        tick(); CDB_in_write = 1'b0;
        wait_rts("sub");
        do_xmit("sub");

        // fill all three stations, then a rejected fourth issue
        drive_issue(3'b101, 32'd15, 32'd60, 1'b0, 1'b0);
        push_exp(model(3'b101, 32'd15, 32'd60), 6'd1);
        tick();
        check("fill_issued0", 64'(issued), 64'b001);
        drive_issue(3'b000, 32'd25, 32'd35, 1'b0, 1'b0);
        push_exp(model(3'b000, 32'd25, 32'd35), 6'd2);
        tick();
        check("fill_issued1", 64'(issued), 64'b010);
        drive_issue(3'b111, 32'd7, 32'd7, 1'b0, 1'b0);
        push_exp(model(3'b111, 32'd7, 32'd7), 6'd3);
        tick();
        check("fill_issued2", 64'(issued), 64'b100);
        check("full_avail", 64'(available), 64'd0);
        drive_issue(3'b000, 32'd1, 32'd1, 1'b0, 1'b0);
        tick(); issue = 1'b0;
        check("full_error", 64'(error), 64'd1);
        check("full_issued", 64'(issued), 64'd0);
        check("full_rs_avail", 64'(RS_available), 64'd0);
        tick();
        check("full_error_pulse", 64'(error), 64'd0);
        repeat (5) tick();
        do_xmit("fill0");
        tick();
        do_xmit("fill1");
        tick();
        do_xmit("fill2");
        check("fill_all_free", 64'(RS_available), 64'b111);

        // two DONE stations drained with CDB_xmit held high
        drive_issue(3'b100, 32'hF0, 32'h0F, 1'b0, 1'b0);
        push_exp(model(3'b100, 32'hF0, 32'h0F), 6'd1);
        tick();
        drive_issue(3'b110, 32'h0F0F, 32'h1234, 1'b0, 1'b0);
        push_exp(model(3'b110, 32'h0F0F, 32'h1234), 6'd2);
        tick(); issue = 1'b0;
        repeat (5) tick();
        CDB_xmit = 1'b1;
        #1; cmp_tx("hold0");
        tick();
        cmp_tx("hold1");
        tick();
        check("hold_rts_drop", 64'(CDB_rts), 64'd0);
        check("hold_write_drop", 64'(CDB_write), 64'd0);
        CDB_xmit = 1'b0;

        // reset while two stations execute; nothing may be transmitted afterwards
        drive_issue(3'b000, 32'd100, 32'd1, 1'b0, 1'b0);
        tick();
        drive_issue(3'b000, 32'd200, 32'd2, 1'b0, 1'b0);
        tick(); issue = 1'b0;
        tick();
        check("flush_exec", 64'(RS_executing), 64'b011);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("flush_rs_avail", 64'(RS_available), 64'b111);
        check("flush_exec_clr", 64'(RS_executing), 64'd0);
        check("flush_rts", 64'(CDB_rts), 64'd0);
        check("flush_data", 64'(CDB_data), 64'd0);
        check("flush_src", 64'(CDB_source), 64'd0);
        check("flush_issued", 64'(issued), 64'd0);
        check("flush_error", 64'(error), 64'd0);
        CDB_xmit = 1'b1; flush_win = 1'b1;
        repeat (6) tick();
        flush_win = 1'b0; CDB_xmit = 1'b0;
        check("flush_stray_writes", 64'(stray), 64'd0);

        // opcode 010: shift when enabled, rejected otherwise
        drive_issue(3'b010, 32'd1, 32'd4, 1'b0, 1'b0);
`ifdef ALU_SHIFT_EN
        push_exp(32'd16, 6'd1);
        tick(); issue = 1'b0;
        check("shl_issued", 64'(issued), 64'b001);
        check("shl_error", 64'(error), 64'd0);
        wait_rts("shl");
        do_xmit("shl");
`else
        tick(); issue = 1'b0;
        check("shl_error", 64'(error), 64'd1);
        check("shl_issued", 64'(issued), 64'd0);
        check("shl_no_alloc", 64'(RS_available), 64'b111);
        repeat (4) tick();
        check("shl_no_rts", 64'(CDB_rts), 64'd0);
`endif
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_rs_unit.md
Name: alu_rs_unit

Overview:
- Parametrised Tomasulo integer ALU functional unit with NUM_RS reservation stations and an EXEC_LAT-cycle pipelined execute stage.
- Snoops the common data bus (CDB) for pending operand tags.
- Arbitrates its own finished results onto the CDB using the CDB_rts/CDB_xmit handshake.
- Drop-in successor to the fixed three-station adder unit, with operand tags and a configurable width, depth and latency.

Parameters:
WIDTH, 32, operand/result width in bits
NUM_RS, 3, number of reservation stations (1..16)
TAG_W, 6, width of CDB source/tag fields
TAG_BASE, 1, tag of station 0; station i broadcasts tag TAG_BASE+i (never 0)
EXEC_LAT, 2, execute latency in cycles, from start to DONE (>=1)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
issue  in  1  issue request this cycle
opcode  in  6  operation; [2:0] is the function, [5:3] is ignored
A  in  WIDTH  operand A value, or its producer tag in [TAG_W-1:0] when A_invalid
B  in  WIDTH  operand B value, or its producer tag when B_invalid
A_invalid  in  1  A not yet produced
B_invalid  in  1  B not yet produced
CDB_in_write  in  1  CDB broadcast valid (snoop)
CDB_in_source  in  TAG_W  tag being broadcast
CDB_in_data  in  WIDTH  value being broadcast
CDB_xmit  in  1  CDB grant to this unit
CDB_data  out  WIDTH  result driven on CDB
CDB_source  out  TAG_W  tag of the transmitting station
CDB_write  out  1  result valid on CDB
CDB_rts  out  1  at least one station holds a finished result
available  out  1  at least one station is FREE
RS_available  out  NUM_RS  per-station FREE flags
issued  out  NUM_RS  one-hot station accepted by the last issue
RS_executing  out  NUM_RS  per-station EXEC flags
error  out  1  one-cycle pulse on a rejected issue

Behaviour:
- Reset (synchronous, also mid-operation):
  - All stations go FREE and the in-flight pipeline is flushed.
  - CDB_data=0, CDB_source=0, CDB_write=0, CDB_rts=0, issued=0, RS_executing=0, error=0.
  - available=1, RS_available=all ones.
- Per-station FSM: FREE -> WAIT (some operand invalid) or READY (both valid) -> EXEC -> DONE -> FREE.
- Issue:
  - When issue=1, available=1 and opcode is legal, the lowest-index FREE station is allocated at the clock edge.
  - issued is one-hot for exactly the following cycle, then 0.
- Rejected issue: issue=1 with available=0, or issue=1 with an illegal opcode. No allocation occurs, and error pulses for one cycle.
- Snoop:
  - Each WAIT station with an invalid operand whose tag equals CDB_in_source captures CDB_in_data when CDB_in_write=1.
  - A station whose operands both become valid moves to READY at the next edge.
  - Issue-cycle bypass: an operand whose tag matches the same-cycle CDB broadcast is stored as valid, so the station goes straight to READY.
- Execute start: at most one station per cycle moves READY -> EXEC, lowest index first. A station can start the cycle after it becomes READY.
- Execute completion:
  - The result is written into the station EXEC_LAT cycles after start, and the station enters DONE.
  - Starts are pipelined, so back-to-back starts are allowed.
- Functions:
  - 000 add, 001 sub (A-B), 100 or, 101 and, 110 not (~A, B ignored), 111 xor.
  - Results wrap modulo 2^WIDTH; no overflow flag.
  - 010 and 011 are illegal unless ALU_SHIFT_EN is defined.
- CDB_rts is combinational: 1 whenever any station is DONE.
- Transmit:
  - When CDB_xmit=1 and CDB_rts=1, the lowest-index DONE station drives CDB_data and CDB_source in the same cycle, with CDB_write=1.
  - That station goes FREE at the edge.
  - When CDB_xmit=0 or no station is DONE: CDB_write=0, CDB_data=0, CDB_source=0.
- Simultaneous events:
  - A station freed by transmit is not reusable by an issue in the same cycle; it is available next cycle.
  - The unit does not snoop its own transmission unless that transmission also appears on CDB_in.
- Full: with all stations non-FREE, available=0; a further issue raises error and changes no state.

Optional Feature:
- Macro: ALU_SHIFT_EN.
- Defined:
  - 010 = logical left shift of A by B[$clog2(WIDTH)-1:0].
  - 011 = arithmetic right shift of A by the same amount.
  - Both are legal and have the same latency as other functions.
- Undefined: 010 and 011 are illegal, raise error, and allocate nothing.

Test Plan:
- Reset, then issue add A=5 B=5 -> issued=001 next cycle; RS_executing[0] set. After EXEC_LAT cycles CDB_rts=1. With CDB_xmit=1: CDB_data=10, CDB_source=1, CDB_write=1; station 0 then FREE.
- Issue sub with A_invalid=1 (tag 9), B=13 -> station stays in WAIT. On CDB_in_write=1, CDB_in_source=9, CDB_in_data=3, the station captures 3 and executes -> CDB_data=0xFFFFFFF6.
- Issue and 15,60 / add 25,35 / xor 7,7 on consecutive cycles -> issued=001, 010, 100. Then available=0, and a fourth issue -> error=1 for one cycle with no state change. Three CDB_xmit pulses deliver 12, 60, 0 with sources 1, 2, 3.
- Two stations DONE and CDB_xmit held 1 for two cycles -> station 0 transmits first, then station 1; CDB_rts drops after the second.
- Assert reset while two stations are in EXEC -> next cycle all outputs hold their reset values and no CDB_write ever appears for the flushed ops.
- opcode 010 with A=1 B=4 -> result 16 with ALU_SHIFT_EN defined; error pulse and no allocation without it.
